// File: rtl/swap_requester_if.sv
// Host command and engine w/done handshake bundle for swap_requester.
// master is the requester side; slave is the host/engine side.
interface swap_requester_if #(
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] n_swaps;
   logic             done_in;
   logic             w;
   logic             busy;
   logic             finished;
   logic [CNT_W-1:0] swaps_done;
   logic             parity;
   logic             err;

   modport master (
      input  start, n_swaps, done_in,
      output w, busy, finished, swaps_done, parity, err
   );

   modport slave (
      output start, n_swaps, done_in,
      input  w, busy, finished, swaps_done, parity, err
   );
endinterface

// File: rtl/swap_requester.sv
// Initiator for the w/done swap handshake: issues N single-cycle w requests, counts
// completions, tracks r1/r2 exchange parity and flags an engine that never responds.
module swap_requester #(
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned ACK_TIMEOUT  = 4,
   parameter int unsigned DONE_TIMEOUT = 16
) (
   input  logic             ck,
   input  logic             rst,
   swap_requester_if.master bus
);

   localparam int unsigned TMax = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
   localparam int unsigned TW   = $clog2(TMax + 1);

   localparam logic [TW-1:0]    TimerOne = TW'(1);
   localparam logic [TW-1:0]    TimerMax = TW'(TMax);
   localparam logic [TW-1:0]    AckLast  = TW'(ACK_TIMEOUT - 1);
   localparam logic [TW-1:0]    DoneLast = TW'(DONE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitAck,
      StWaitDone,
      StFin
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] swaps_done_q, swaps_done_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [TW-1:0]    timer_inc;
   logic             parity_q, parity_d;
   logic             err_q, err_d;
   logic             w_q, w_d;
   logic             finished_q;

   // Saturating so a stalled timer can never wrap back under a threshold.
   assign timer_inc = (timer_q == TimerMax) ? timer_q : timer_q + TimerOne;

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      swaps_done_d = swaps_done_q;
      timer_d      = timer_q;
      parity_d     = parity_q;
      err_d        = err_q;
      w_d          = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               remaining_d  = bus.n_swaps;
               swaps_done_d = '0;
               err_d        = 1'b0;
               timer_d      = '0;
               state_d      = (bus.n_swaps == '0) ? StFin : StIssue;
            end
         end

         StIssue: begin
            if (bus.done_in) begin
               w_d     = 1'b1;
               timer_d = '0;
               state_d = StWaitAck;
            end
         end

         StWaitAck: begin
            if (!bus.done_in) begin
               timer_d = '0;
               state_d = StWaitDone;
            end else begin
               timer_d = timer_inc;
               if (timer_q >= AckLast) begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end
            end
         end

         StWaitDone: begin
            if (bus.done_in) begin
               swaps_done_d = swaps_done_q + CntOne;
               parity_d     = ~parity_q;
               remaining_d  = remaining_q - CntOne;
               state_d      = (remaining_q == CntOne) ? StFin : StIssue;
            end else begin
               timer_d = timer_inc;
               if (timer_q >= DoneLast) begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end
            end
         end

         StFin: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         remaining_q  <= '0;
         swaps_done_q <= '0;
         timer_q      <= '0;
         parity_q     <= 1'b0;
         err_q        <= 1'b0;
         w_q          <= 1'b0;
         finished_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         swaps_done_q <= swaps_done_d;
         timer_q      <= timer_d;
         parity_q     <= parity_d;
         err_q        <= err_d;
         w_q          <= w_d;
         finished_q   <= (state_q == StFin);
      end
   end

   assign bus.w          = w_q;
   assign bus.busy       = (state_q != StIdle) && (state_q != StFin);
   assign bus.finished   = finished_q;
   assign bus.swaps_done = swaps_done_q;
   assign bus.parity     = parity_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_swap_requester.sv
// Directed bench for swap_requester with a small 3-cycle swap engine model.
module tb_swap_requester;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned ACK_TO  = 4;
   localparam int unsigned DONE_TO = 16;

   logic ck  = 1'b0;
   logic rst = 1'b0;

   swap_requester_if #(.CNT_W(CNT_W)) bus ();

   swap_requester #(
      .CNT_W        (CNT_W),
      .ACK_TIMEOUT  (ACK_TO),
      .DONE_TIMEOUT (DONE_TO)
   ) dut (
      .ck  (ck),
      .rst (rst),
      .bus (bus)
   );

   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   // Engine modes: 0 normal, 1 done stuck high, 2 done stuck low.
   int mode    = 0;
   int low_cnt = 0;

   always @(posedge ck or posedge rst) begin
      if (rst) begin
         low_cnt     <= 0;
         bus.done_in <= 1'b1;
      end else if (mode == 1) begin
         bus.done_in <= 1'b1;
      end else if (mode == 2) begin
         bus.done_in <= 1'b0;
      end else if (bus.w) begin
         low_cnt     <= 2;
         bus.done_in <= 1'b0;
      end else if (low_cnt > 0) begin
         low_cnt     <= low_cnt - 1;
         bus.done_in <= 1'b0;
      end else begin
         bus.done_in <= 1'b1;
      end
   end

   int   w_pulses = 0;
   int   w_long   = 0;
   int   w_low    = 0;
   int   fin_cnt  = 0;
   logic w_prev   = 1'b0;

   always @(posedge ck) begin
      if (bus.w === 1'b1) w_pulses++;
      if (bus.w === 1'b1 && w_prev === 1'b1) w_long++;
      if (bus.w === 1'b1 && bus.done_in !== 1'b1) w_low++;
      if (bus.finished === 1'b1) fin_cnt++;
      w_prev = bus.w;
   end

   task automatic do_reset();
      @(negedge ck);
      bus.start = 1'b0;
      mode      = 0;
      rst       = 1'b1;
      @(negedge ck);
      rst = 1'b0;
   endtask

   task automatic send(input int n);
      @(negedge ck);
      bus.start   = 1'b1;
      bus.n_swaps = n[CNT_W-1:0];
      @(negedge ck);
      bus.start = 1'b0;
   endtask

   task automatic wait_fin(input int budget, output bit ok, output int cycles);
      ok     = 1'b0;
      cycles = 0;
      while (!ok && cycles < budget) begin
         @(posedge ck);
         #1;
         cycles++;
         if (bus.finished === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic wait_w(input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         @(posedge ck);
         #1;
         n++;
         if (bus.w === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [CNT_W+4:0] outs;
      bus.start   = 1'b0;
      bus.n_swaps = '0;
      #1 rst = 1'b1;
      #1;
      outs = {bus.w, bus.busy, bus.finished, bus.parity, bus.err, bus.swaps_done};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", outs);
      end
      repeat (2) @(negedge ck);
      rst = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.w !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b w=%b want 0 0", bus.busy, bus.w);
      end
   endtask

   task automatic test_single();
      bit ok;
      int cyc;
      int wp;
      do_reset();
      wp = w_pulses;
      send(1);
      wait_fin(50, ok, cyc);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_finished got 0 want 1 within 50 cycles");
      end
      checks++;
      if (bus.swaps_done !== 8'd1 || bus.parity !== 1'b1 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL single_result got done=%0d par=%b err=%b want 1 1 0",
                  bus.swaps_done, bus.parity, bus.err);
      end
      checks++;
      if (w_pulses - wp !== 1) begin
         errors++;
         $display("FAIL single_w_pulses got %0d want 1", w_pulses - wp);
      end
      @(posedge ck);
      #1;
      checks++;
      if (bus.finished !== 1'b0 || bus.swaps_done !== 8'd1) begin
         errors++;
         $display("FAIL single_hold got fin=%b done=%0d want 0 1", bus.finished, bus.swaps_done);
      end
   endtask

   task automatic test_back_to_back(input int n, input logic exp_par);
      bit ok;
      int cyc;
      int wp, wl, wlo;
      do_reset();
      wp  = w_pulses;
      wl  = w_long;
      wlo = w_low;
      send(n);
      wait_fin(n * 8 + 50, ok, cyc);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_finished n=%0d got 0 want 1", n);
      end
      checks++;
      if (w_pulses - wp !== n || w_long - wl !== 0 || w_low - wlo !== 0) begin
         errors++;
         $display("FAIL b2b_w n=%0d got pulses=%0d long=%0d low=%0d want %0d 0 0",
                  n, w_pulses - wp, w_long - wl, w_low - wlo, n);
      end
      checks++;
      if (bus.swaps_done !== n[CNT_W-1:0] || bus.parity !== exp_par || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_result n=%0d got done=%0d par=%b err=%b want %0d %b 0",
                  n, bus.swaps_done, bus.parity, bus.err, n, exp_par);
      end
   endtask

   task automatic test_zero();
      int wp;
      do_reset();
      wp = w_pulses;
      @(negedge ck);
      bus.start   = 1'b1;
      bus.n_swaps = '0;
      @(posedge ck);
      #1;
      bus.start = 1'b0;
      checks++;
      if (bus.finished !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_cycle1 got fin=%b busy=%b want 0 0", bus.finished, bus.busy);
      end
      @(posedge ck);
      #1;
      checks++;
      if (bus.finished !== 1'b1 || bus.swaps_done !== 8'd0 || w_pulses != wp) begin
         errors++;
         $display("FAIL zero_cycle2 got fin=%b done=%0d w=%0d want 1 0 0",
                  bus.finished, bus.swaps_done, w_pulses - wp);
      end
   endtask

   task automatic test_ack_timeout();
      bit ok;
      int cyc;
      do_reset();
      mode = 1;
      send(2);
      wait_w(10, ok);
      wait_fin(30, ok, cyc);
      checks++;
      if (!ok || cyc != ACK_TO + 1) begin
         errors++;
         $display("FAIL ack_timeout_latency got ok=%b cyc=%0d want 1 %0d", ok, cyc, ACK_TO + 1);
      end
      checks++;
      if (bus.err !== 1'b1 || bus.swaps_done !== 8'd0) begin
         errors++;
         $display("FAIL ack_timeout_err got err=%b done=%0d want 1 0", bus.err, bus.swaps_done);
      end
      mode = 0;
      send(1);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("FAIL ack_timeout_clear got err=%b want 0", bus.err);
      end
      wait_fin(50, ok, cyc);
      checks++;
      if (!ok || bus.swaps_done !== 8'd1 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL ack_timeout_recover got ok=%b done=%0d err=%b want 1 1 0",
                  ok, bus.swaps_done, bus.err);
      end
   endtask

   task automatic test_done_timeout();
      bit ok;
      int cyc;
      do_reset();
      send(1);
      wait_w(10, ok);
      mode = 2;
      wait_fin(60, ok, cyc);
      checks++;
      if (!ok || cyc != DONE_TO + 3) begin
         errors++;
         $display("FAIL done_timeout_latency got ok=%b cyc=%0d want 1 %0d", ok, cyc, DONE_TO + 3);
      end
      checks++;
      if (bus.err !== 1'b1 || bus.swaps_done !== 8'd0 || bus.parity !== 1'b0) begin
         errors++;
         $display("FAIL done_timeout_err got err=%b done=%0d par=%b want 1 0 0",
                  bus.err, bus.swaps_done, bus.parity);
      end
      mode = 0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int spins;
      int fc;
      logic [CNT_W+4:0] outs;
      do_reset();
      send(4);
      spins = 0;
      while (bus.swaps_done !== 8'd1 && spins < 40) begin
         @(posedge ck);
         #1;
         spins++;
      end
      wait_w(20, ok);
      repeat (2) @(posedge ck);
      #2;
      checks++;
      if (!ok || bus.busy !== 1'b1 || bus.done_in !== 1'b0 || bus.swaps_done !== 8'd1) begin
         errors++;
         $display("FAIL reset_mid_setup got ok=%b busy=%b done_in=%b done=%0d want 1 1 0 1",
                  ok, bus.busy, bus.done_in, bus.swaps_done);
      end
      fc  = fin_cnt;
      rst = 1'b1;
      #1;
      outs = {bus.w, bus.busy, bus.finished, bus.parity, bus.err, bus.swaps_done};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got %b want 0", outs);
      end
      @(negedge ck);
      rst = 1'b0;
      repeat (10) @(posedge ck);
      #1;
      checks++;
      if (fin_cnt != fc || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_abandon got fin=%0d busy=%b want 0 0", fin_cnt - fc, bus.busy);
      end
   endtask

   task automatic test_start_busy();
      bit ok;
      int cyc;
      int wp;
      do_reset();
      wp = w_pulses;
      send(2);
      @(negedge ck);
      bus.start   = 1'b1;
      bus.n_swaps = 8'd5;
      repeat (3) @(negedge ck);
      bus.start = 1'b0;
      wait_fin(60, ok, cyc);
      checks++;
      if (!ok || bus.swaps_done !== 8'd2 || w_pulses - wp != 2) begin
         errors++;
         $display("FAIL start_busy got ok=%b done=%0d w=%0d want 1 2 2",
                  ok, bus.swaps_done, w_pulses - wp);
      end
      repeat (4) @(posedge ck);
      #1;
      checks++;
      if (bus.busy !== 1'b0 || w_pulses - wp != 2) begin
         errors++;
         $display("FAIL start_busy_idle got busy=%b w=%0d want 0 2", bus.busy, w_pulses - wp);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back(3, 1'b1);
      test_back_to_back(2, 1'b0);
      test_zero();
      test_ack_timeout();
      test_done_timeout();
      test_reset_mid();
      test_start_busy();
      test_back_to_back(255, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
